// File: rtl/cw_target_pwrseq.sv
`default_nettype none
// ============================================================================
// Module   : cw_target_pwrseq
// Brief    : Target power/reset sequencer with AVR programming-pin arbitration.
// Revision : 1.0
// ============================================================================
module cw_target_pwrseq #(
    parameter int pCNT_WIDTH         = 24,
    parameter int pPOWER_ON_AT_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic [pCNT_WIDTH-1:0] cfg_off_cycles,
    input  logic [pCNT_WIDTH-1:0] cfg_settle_cycles,
    input  logic [pCNT_WIDTH-1:0] cfg_rst_hold_cycles,
    input  logic                  cmd_cycle,
    input  logic                  cmd_off,
    input  logic                  cmd_on,
    input  logic                  avrprog_req,
    output logic                  avrprog_gnt,
    output logic                  targetpower_off,
    output logic                  target_highz,
    output logic                  nrst_oe,
    output logic                  nrst_o,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            state_o
);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_OFF_WAIT = 3'd1,
        S_SETTLE   = 3'd2,
        S_RSTHOLD  = 3'd3,
        S_ON       = 3'd4,
        S_PROG     = 3'd5
    } state_t;

    localparam logic                  c_BOOT    = (pPOWER_ON_AT_RESET != 0);
    localparam logic [pCNT_WIDTH-1:0] c_CNT_ONE = {{(pCNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_next;
    logic [pCNT_WIDTH-1:0] r_cnt;
    logic [pCNT_WIDTH-1:0] w_load;
    logic                  w_expired;
    logic                  r_boot;
    logic                  r_done;
    logic                  r_pwr_off;
    logic                  r_highz;
    logic                  r_nrst_oe;
    logic                  r_nrst_o;
    logic                  r_gnt;
    logic                  r_busy;

    // Output bundle: {targetpower_off, target_highz, nrst_oe, nrst_o, avrprog_gnt, busy}
    function automatic logic [5:0] f_decode(input state_t s);
        case (s)
            S_OFF, S_OFF_WAIT: f_decode = 6'b11_0000 | {5'b0, s == S_OFF_WAIT};
            S_SETTLE:          f_decode = 6'b01_0001;
            S_RSTHOLD:         f_decode = 6'b00_1001;
            S_ON:              f_decode = 6'b00_0000;
            S_PROG:            f_decode = 6'b00_0010;
            default:           f_decode = 6'b11_0000;
        endcase
    endfunction

    assign w_expired = (r_cnt == '0);

    always_comb begin
        w_next = r_state;
        if (cmd_off) begin
            w_next = S_OFF;
        end else begin
            case (r_state)
                S_OFF:      if (cmd_cycle || cmd_on || r_boot) w_next = S_SETTLE;
                S_OFF_WAIT: if (w_expired) w_next = S_SETTLE;
                S_SETTLE:   if (w_expired) w_next = S_RSTHOLD;
                S_RSTHOLD:  if (w_expired) w_next = S_ON;
                S_ON: begin
                    if (cmd_cycle)        w_next = S_OFF_WAIT;
                    else if (avrprog_req) w_next = S_PROG;
                end
                // Leaving programming always re-runs the reset pulse.
                S_PROG:     if (!avrprog_req) w_next = S_RSTHOLD;
                default:    w_next = S_OFF;
            endcase
        end
    end

    always_comb begin
        w_load = '0;
        case (w_next)
            S_OFF_WAIT: w_load = cfg_off_cycles;
            S_SETTLE:   w_load = cfg_settle_cycles;
            S_RSTHOLD:  w_load = cfg_rst_hold_cycles;
            default:    w_load = '0;
        endcase
    end

    // Outputs are registered from the next state so they track r_state exactly.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_OFF;
            r_cnt   <= '0;
            r_boot  <= c_BOOT;
            r_done  <= 1'b0;
            {r_pwr_off, r_highz, r_nrst_oe, r_nrst_o, r_gnt, r_busy} <= f_decode(S_OFF);
        end else begin
            r_state <= w_next;
            r_boot  <= 1'b0;
            if (w_next != r_state)
                r_cnt <= w_load;
            else if (!w_expired)
                r_cnt <= r_cnt - c_CNT_ONE;
            r_done  <= (r_state == S_RSTHOLD) && (w_next == S_ON);
            {r_pwr_off, r_highz, r_nrst_oe, r_nrst_o, r_gnt, r_busy} <= f_decode(w_next);
        end
    end

    assign avrprog_gnt     = r_gnt;
    assign targetpower_off = r_pwr_off;
    assign target_highz    = r_highz;
    assign nrst_oe         = r_nrst_oe;
    assign nrst_o          = r_nrst_o;
    assign busy            = r_busy;
    assign done            = r_done;
    assign state_o         = r_state;

endmodule
`default_nettype wire
